symbol_decoder: RTL and testbench
=================================

# symbol_decoder

Receive-side counterpart of the symbol generator: accepts the 8-bit symbol stream and maps each code back to its 4-bit index through the fixed 16-entry symbol table. It flags codes not in the table and tracks stream lock with a hunt/locked state machine. While locked, it counts hits on a selectable target index and counts decode errors. It sits between the symbol source and the counter/display logic, with valid/ready on both sides.

## Interface
- LOCK_N, default 4: consecutive good symbols needed to go HUNT→LOCKED (1..15).
- LOSS_N, default 3: consecutive bad symbols needed to go LOCKED→HUNT (1..15).
- CNT_W, default 16: width of the hit and error counters.

- ClkSymDec  in  1  clock; all state updates on the rising edge.
- RstN  in  1  asynchronous, active-low reset.
- SymValid  in  1  SymIn holds a symbol.
- SymReady  out  1  decoder can accept a symbol this cycle.
- SymIn  in  8  received symbol code.
- IdxValid  out  1  IdxOut/SymErr hold a decoded result.
- IdxReady  in  1  downstream accepts the result.
- IdxOut  out  4  decoded index; 0 when SymErr=1.
- SymErr  out  1  code not in the table.
- TargetIdx  in  4  index whose occurrences are counted; sampled at each accept.
- CntClear  in  1  synchronous clear of both counters and CountSat.
- Locked  out  1  state machine is in LOCKED.
- HitCount  out  CNT_W  good symbols equal to TargetIdx accepted while locked.
- ErrCount  out  CNT_W  bad symbols accepted while locked.
- CountSat  out  1  sticky; set when either counter saturates.

## Operation
- Table, index→code (hex): 0 EA, 1 F1, 2 D6, 3 89, 4 9E, 5 E5, 6 B6, 7 BF, 8 DA, 9 D5, 10 E6, 11 9D, 12 F8, 13 B3, 14 F4, 15 ED. Any other code is bad.
- Accept = SymValid && SymReady. SymReady = !IdxValid || IdxReady, so there is a single output register and no bubble under continuous flow.
- On accept: IdxOut/SymErr load the decode of SymIn and IdxValid=1. Otherwise, on IdxReady, IdxValid=0. The output is held stable while IdxValid && !IdxReady.
- The state machine advances only on accept.
  - HUNT: good symbol → goodRun+1; bad symbol → goodRun=0. When goodRun reaches LOCK_N, move to LOCKED with badRun=0.
  - LOCKED: bad symbol → badRun+1; good symbol → badRun=0. When badRun reaches LOSS_N, move to HUNT with goodRun=0.
- Counting happens only for accepts made while already in LOCKED, evaluated before the state update.
  - HitCount +1 if the symbol is good and the index equals TargetIdx.
  - ErrCount +1 if the symbol is bad, including the bad symbol that causes loss of lock.
- The symbol that completes LOCK_N is not counted.
- Counters saturate at 2^CNT_W−1 and never wrap. Reaching saturation sets CountSat.
- CntClear zeroes HitCount, ErrCount and CountSat. It has priority over a same-cycle increment. It does not affect lock state or the pipeline.

## Timing
- Reset values: SymReady=1 (combinational from IdxValid=0), IdxValid=0, IdxOut=0, SymErr=0, Locked=0 (HUNT), goodRun=badRun=0, HitCount=0, ErrCount=0, CountSat=0.
- Latency: a symbol accepted at edge k appears on IdxOut/SymErr after edge k.
- Locked, HitCount and ErrCount update at the same edge as the accept.
- Reset asserted mid-stream clears everything immediately, without waiting for a clock edge. Any in-flight result is dropped. The first accept after RstN deasserts starts a fresh hunt.
- A TargetIdx change takes effect on the next accept. Past counts are unchanged.
- SymIn is ignored when SymValid=0 or SymReady=0. Neither counters nor run lengths change.

## Test plan
- Reset, then send EA,F1,D6,89 with IdxReady=1 → IdxOut 0,1,2,3 one cycle after each accept; Locked=1 after the 4th accept; HitCount=0 (TargetIdx=0, locking symbols not counted).
- Once locked with TargetIdx=5, send E5,E5,ED → HitCount=2, ErrCount=0; then send 00,FF,00 → ErrCount=3, SymErr=1 with IdxOut=0 each time, Locked drops after the 3rd bad symbol.
- Backpressure: IdxReady=0 for 3 cycles with a result pending → SymReady=0, IdxOut held, no counter change; release → next symbol accepted in the same cycle.
- CNT_W=2, locked, TargetIdx=15, send ED ×5 → HitCount=3, CountSat=1; assert CntClear in the same cycle as a hit → HitCount=0, CountSat=0.
- While locked in HUNT progress, assert RstN low mid-stream → all outputs at reset values asynchronously; after release, 3 good symbols leave Locked=0 and the 4th sets it.
- Alternate good/bad symbols in HUNT → Locked stays 0; alternate while LOCKED → Locked stays 1 and ErrCount counts every bad symbol.

Source files
------------

// File: rtl/symbol_decoder.sv
// symbol_decoder: maps 8-bit line symbols back to 4-bit indices,
// tracks stream lock and counts target hits and decode errors.
module symbol_decoder #(
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 3,
  parameter int CNT_W  = 16
) (
  input  logic             ClkSymDec,
  input  logic             RstN,
  input  logic             SymValid,
  output logic             SymReady,
  input  logic [7:0]       SymIn,
  output logic             IdxValid,
  input  logic             IdxReady,
  output logic [3:0]       IdxOut,
  output logic             SymErr,
  input  logic [3:0]       TargetIdx,
  input  logic             CntClear,
  output logic             Locked,
  output logic [CNT_W-1:0] HitCount,
  output logic [CNT_W-1:0] ErrCount,
  output logic             CountSat
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [3:0]       LOCK_THR = 4'(LOCK_N);
  localparam logic [3:0]       LOSS_THR = 4'(LOSS_N);

  state_e           state_q, state_d;
  logic [3:0]       good_q, good_d;
  logic [3:0]       bad_q, bad_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] errc_q, errc_d;
  logic             sat_q, sat_d;
  logic             vld_q;
  logic [3:0]       idx_q;
  logic             serr_q;

  logic       acc;
  logic [3:0] dec_idx;
  logic       dec_bad;
  logic [3:0] good_inc;
  logic [3:0] bad_inc;

  assign SymReady = !vld_q || IdxReady;
  assign acc      = SymValid && SymReady;

  always_comb begin
    dec_idx = 4'd0;
    dec_bad = 1'b0;
    unique case (SymIn)
      8'hEA: dec_idx = 4'd0;
      8'hF1: dec_idx = 4'd1;
      8'hD6: dec_idx = 4'd2;
      8'h89: dec_idx = 4'd3;
      8'h9E: dec_idx = 4'd4;
      8'hE5: dec_idx = 4'd5;
      8'hB6: dec_idx = 4'd6;
      8'hBF: dec_idx = 4'd7;
      8'hDA: dec_idx = 4'd8;
      8'hD5: dec_idx = 4'd9;
      8'hE6: dec_idx = 4'd10;
      8'h9D: dec_idx = 4'd11;
      8'hF8: dec_idx = 4'd12;
      8'hB3: dec_idx = 4'd13;
      8'hF4: dec_idx = 4'd14;
      8'hED: dec_idx = 4'd15;
      default: dec_bad = 1'b1;
    endcase
  end

  assign good_inc = good_q + 4'd1;
  assign bad_inc  = bad_q + 4'd1;

  // Counting looks at state_q, so the accept that locks is never counted
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    hit_d   = hit_q;
    errc_d  = errc_q;
    sat_d   = sat_q;
    if (acc) begin
      unique case (state_q)
        HUNT: begin
          if (dec_bad) begin
            good_d = 4'd0;
          end else begin
            good_d = good_inc;
            if (good_inc == LOCK_THR) begin
              state_d = LOCKED;
              bad_d   = 4'd0;
            end
          end
        end
        LOCKED: begin
          if (dec_bad) begin
            bad_d = bad_inc;
            if (errc_q != CNT_MAX) errc_d = errc_q + 1'b1;
            if (bad_inc == LOSS_THR) begin
              state_d = HUNT;
              good_d  = 4'd0;
            end
          end else begin
            bad_d = 4'd0;
            if (dec_idx == TargetIdx && hit_q != CNT_MAX)
              hit_d = hit_q + 1'b1;
          end
        end
      endcase
    end
    if (hit_d == CNT_MAX || errc_d == CNT_MAX) sat_d = 1'b1;
    if (CntClear) begin
      hit_d  = '0;
      errc_d = '0;
      sat_d  = 1'b0;
    end
  end

  always_ff @(posedge ClkSymDec or negedge RstN) begin
    if (!RstN) begin
      state_q <= HUNT;
      good_q  <= 4'd0;
      bad_q   <= 4'd0;
      hit_q   <= '0;
      errc_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      hit_q   <= hit_d;
      errc_q  <= errc_d;
      sat_q   <= sat_d;
    end
  end

  always_ff @(posedge ClkSymDec or negedge RstN) begin
    if (!RstN) begin
      vld_q  <= 1'b0;
      idx_q  <= 4'd0;
      serr_q <= 1'b0;
    end else if (acc) begin
      vld_q  <= 1'b1;
      idx_q  <= dec_idx;
      serr_q <= dec_bad;
    end else if (IdxReady) begin
      vld_q  <= 1'b0;
    end
  end

  assign IdxValid = vld_q;
  assign IdxOut   = idx_q;
  assign SymErr   = serr_q;
  assign Locked   = (state_q == LOCKED);
  assign HitCount = hit_q;
  assign ErrCount = errc_q;
  assign CountSat = sat_q;

endmodule

// File: tb/tb_symbol_decoder.sv
// tb_symbol_decoder: scoreboarded stream tests for symbol_decoder,
// with a CNT_W=2 instance alongside for saturation.
module tb_symbol_decoder;

  logic        clk = 1'b0;
  logic        RstN = 1'b0;
  logic        SymValid = 1'b0;
  logic [7:0]  SymIn = 8'h00;
  logic        IdxReady = 1'b1;
  logic [3:0]  TargetIdx = 4'd0;
  logic        CntClear = 1'b0;

  logic        SymReady, IdxValid, SymErr, Locked, CountSat;
  logic [3:0]  IdxOut;
  logic [15:0] HitCount, ErrCount;

  logic        r2, v2, se2, l2, s2;
  logic [3:0]  i2;
  logic [1:0]  h2, e2;

  int checks = 0;
  int errors = 0;
  logic [4:0] sbq[$];

  localparam logic [7:0] TBL [16] = '{
    8'hEA, 8'hF1, 8'hD6, 8'h89, 8'h9E, 8'hE5, 8'hB6, 8'hBF,
    8'hDA, 8'hD5, 8'hE6, 8'h9D, 8'hF8, 8'hB3, 8'hF4, 8'hED};

  always #5 clk = ~clk;

  symbol_decoder dut (
    .ClkSymDec(clk), .RstN(RstN), .SymValid(SymValid),
    .SymReady(SymReady), .SymIn(SymIn), .IdxValid(IdxValid),
    .IdxReady(IdxReady), .IdxOut(IdxOut), .SymErr(SymErr),
    .TargetIdx(TargetIdx), .CntClear(CntClear), .Locked(Locked),
    .HitCount(HitCount), .ErrCount(ErrCount), .CountSat(CountSat));

  symbol_decoder #(.CNT_W(2)) dut2 (
    .ClkSymDec(clk), .RstN(RstN), .SymValid(SymValid),
    .SymReady(r2), .SymIn(SymIn), .IdxValid(v2),
    .IdxReady(IdxReady), .IdxOut(i2), .SymErr(se2),
    .TargetIdx(TargetIdx), .CntClear(CntClear), .Locked(l2),
    .HitCount(h2), .ErrCount(e2), .CountSat(s2));

  function automatic logic [4:0] model(input logic [7:0] c);
    logic [4:0] r;
    r = 5'h10;
    for (int i = 0; i < 16; i++)
      if (TBL[i] == c) r = {1'b0, 4'(i)};
    return r;
  endfunction

  always @(negedge clk) begin
    #2;
    if (RstN && IdxValid && IdxReady) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: got err=%0b idx=%0d with nothing expected",
                 SymErr, IdxOut);
      end else begin
        logic [4:0] e;
        e = sbq.pop_front();
        if ({SymErr, IdxOut} !== e) begin
          errors++;
          $display("FAIL sb_decode: got err=%0b idx=%0d want err=%0b idx=%0d",
                   SymErr, IdxOut, e[4], e[3:0]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    SymValid = 1'b1;
    SymIn    = c;
    #1;
    while (!SymReady && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!SymReady) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: SymReady=0 want 1 for code %h", c);
      SymValid = 1'b0;
      return;
    end
    sbq.push_back(model(c));
    @(posedge clk);
    #1;
    SymValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    SymValid = 1'b0;
    CntClear = 1'b0;
    IdxReady = 1'b1;
    RstN     = 1'b0;
    repeat (2) @(negedge clk);
    RstN = 1'b1;
    sbq.delete();
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, 32'(SymReady), 1);
    chk({nm, "_valid"}, 32'(IdxValid), 0);
    chk({nm, "_idx"}, 32'(IdxOut), 0);
    chk({nm, "_err"}, 32'(SymErr), 0);
    chk({nm, "_locked"}, 32'(Locked), 0);
    chk({nm, "_hit"}, 32'(HitCount), 0);
    chk({nm, "_errc"}, 32'(ErrCount), 0);
    chk({nm, "_sat"}, 32'(CountSat), 0);
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    chk_reset_vals("reset");
    chk("reset_hit2", 32'(h2), 0);
  endtask

  task automatic test_lock();
    logic [7:0] seq [4];
    seq = '{8'hEA, 8'hF1, 8'hD6, 8'h89};
    TargetIdx = 4'd0;
    IdxReady  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(seq[i]);
      chk($sformatf("lock_state%0d", i), 32'(Locked), (i == 3) ? 1 : 0);
    end
    chk("lock_hit", 32'(HitCount), 0);
  endtask

  task automatic test_count();
    TargetIdx = 4'd5;
    send(8'hE5);
    send(8'hE5);
    send(8'hED);
    chk("cnt_hit", 32'(HitCount), 2);
    chk("cnt_err0", 32'(ErrCount), 0);
    send(8'h00);
    chk("bad1_err", 32'(ErrCount), 1);
    chk("bad1_lock", 32'(Locked), 1);
    send(8'hFF);
    chk("bad2_err", 32'(ErrCount), 2);
    chk("bad2_lock", 32'(Locked), 1);
    send(8'h00);
    chk("bad3_err", 32'(ErrCount), 3);
    chk("bad3_lock", 32'(Locked), 0);
    chk("bad3_symerr", 32'(SymErr), 1);
    chk("bad3_idx", 32'(IdxOut), 0);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    IdxReady = 1'b0;
    send(8'hD6);
    SymValid = 1'b1;
    SymIn    = 8'hF1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_ready%0d", i), 32'(SymReady), 0);
      chk($sformatf("bp_valid%0d", i), 32'(IdxValid), 1);
      chk($sformatf("bp_idx%0d", i), 32'(IdxOut), 2);
      chk($sformatf("bp_errc%0d", i), 32'(ErrCount), 3);
      @(negedge clk);
    end
    IdxReady = 1'b1;
    #1;
    chk("bp_release_ready", 32'(SymReady), 1);
    sbq.push_back(model(8'hF1));
    @(posedge clk);
    #1;
    SymValid = 1'b0;
    @(negedge clk);
    chk("bp_next_idx", 32'(IdxOut), 1);
    chk("bp_lock", 32'(Locked), 0);
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 4; i++) send(TBL[i + 4]);
    chk("sat_locked", 32'(l2), 1);
    TargetIdx = 4'd15;
    for (int i = 0; i < 5; i++) send(8'hED);
    chk("sat_hit2", 32'(h2), 3);
    chk("sat_flag2", 32'(s2), 1);
    chk("sat_hit16", 32'(HitCount), 5);
    chk("sat_flag16", 32'(CountSat), 0);
    CntClear = 1'b1;
    send(8'hED);
    CntClear = 1'b0;
    chk("clr_hit2", 32'(h2), 0);
    chk("clr_flag2", 32'(s2), 0);
    chk("clr_hit16", 32'(HitCount), 0);
    chk("clr_locked", 32'(Locked), 1);
    send(8'hED);
    chk("post_clr_hit", 32'(HitCount), 1);
  endtask

  task automatic test_alternate();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      send((i % 2 == 0) ? TBL[i] : 8'h55);
      chk($sformatf("alt_hunt%0d", i), 32'(Locked), 0);
    end
    for (int i = 0; i < 4; i++) send(TBL[i]);
    chk("alt_locked", 32'(Locked), 1);
    for (int i = 0; i < 6; i++) begin
      send((i % 2 == 0) ? 8'h01 : TBL[9]);
      chk($sformatf("alt_lk%0d", i), 32'(Locked), 1);
      chk($sformatf("alt_errc%0d", i), 32'(ErrCount), i / 2 + 1);
    end
  endtask

  task automatic test_reset_mid();
    send(TBL[3]);
    RstN = 1'b0;
    #1;
    chk_reset_vals("mid_locked");
    sbq.delete();
    @(negedge clk);
    RstN = 1'b1;
    send(TBL[1]);
    send(TBL[2]);
    RstN = 1'b0;
    #1;
    chk_reset_vals("mid_hunt");
    sbq.delete();
    @(negedge clk);
    RstN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(TBL[i + 10]);
      chk($sformatf("relock%0d", i), 32'(Locked), (i == 3) ? 1 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_count();
    test_backpressure();
    test_saturate();
    test_alternate();
    test_reset_mid();
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
